// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO read-side consumer.
package fifo_pkg;
  localparam int DEF_DW     = 8;
  localparam int DEF_CW     = 16;
  localparam int SKID_DEPTH = 2;

  // Skid-buffer occupancy, legal values 0..SKID_DEPTH.
  typedef logic [1:0] occ_t;

  function automatic logic occ_full(input occ_t o);
    return o == occ_t'(SKID_DEPTH);
  endfunction
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: head is the oldest word, tail the younger one.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] head,
  output occ_t          occ
);

  logic [DW-1:0] tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == '0) head <= wdata;
          else           tail <= wdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the incoming word queues behind any survivor.
          if (occ_full(occ)) begin
            head <= tail;
            tail <= wdata;
          end else begin
            head <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && occ_full(occ)));
  no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(pop && occ == '0));

endmodule

// File: rtl/fifo_reader.sv
// FIFO read-side consumer: pops a synchronous FIFO and presents a valid/ready stream.
// Optional pop counter on rd_count when FIFO_RD_CNT_EN is defined.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          empty,
  input  logic [DW-1:0] rdata,
  output logic          rd_en,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
`ifdef FIFO_RD_CNT_EN
  output logic [CW-1:0] rd_count,
`endif
  output occ_t          occ
);

  // Stream handshake: a word transfers on every rising edge where
  // out_valid && out_ready; out_valid/out_data hold until that transfer.
  logic       inflight;
  logic       pop;
  logic [1:0] pending;

  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != '0);
  assign pending   = occ + {1'b0, inflight};

  // out_ready reaches rd_en combinationally so a full pipe can refill on the
  // same edge it drains, giving one word per cycle.
  assign rd_en = rst && enable && !empty &&
                 ((pending < 2'd2) || (pending == 2'd2 && pop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inflight <= 1'b0;
    else      inflight <= rd_en;
  end

  fifo_rd_skid #(.DW(DW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .wdata (rdata),
    .pop   (pop),
    .head  (out_data),
    .occ   (occ)
  );

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     rd_count <= '0;
    else if (pop) rd_count <= rd_count + CW'(1);
  end
`endif

  cw_legal: assert property (@(posedge clk) CW >= 1);

endmodule
